// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-flow opcodes, jump controller states, default sizes.
package cpu_pkg;

  localparam int unsigned DefD  = 6;
  localparam int unsigned DefLA = 4;
  localparam int unsigned DefSD = 4;

  typedef enum logic [1:0] {
    OpNone   = 2'b00,
    OpBranch = 2'b01,
    OpCall   = 2'b10,
    OpRet    = 2'b11
  } br_op_t;

  typedef enum logic [0:0] {
    StRun = 1'b0,
    StErr = 1'b1
  } jc_state_t;

endpackage

// File: rtl/link_stack.sv
// Return-address stack; pointer counts stored entries (0..SD), top is the last pushed value.
module link_stack #(
  parameter int unsigned D  = 6,
  parameter int unsigned SD = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [D-1:0] i_din,
  output logic [D-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned IW = $clog2(SD);
  localparam int unsigned PW = IW + 1;

  logic [D-1:0]  r_mem [SD];
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_m1;
  logic [IW-1:0] w_top_idx;
  logic [IW-1:0] w_wr_idx;

  assign w_ptr_m1  = r_ptr - PW'(1);
  assign w_top_idx = w_ptr_m1[IW-1:0];
  assign w_wr_idx  = r_ptr[IW-1:0];

  assign o_full  = (r_ptr == PW'(SD));
  assign o_empty = (r_ptr == '0);
  assign o_top   = r_mem[w_top_idx];

  // Caller guarantees push only when not full and pop only when not empty.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
      for (int i = 0; i < SD; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[w_wr_idx] <= i_din;
      r_ptr           <= r_ptr + PW'(1);
    end else if (i_pop) begin
      r_ptr <= w_ptr_m1;
    end
  end

endmodule

// File: rtl/jump_ctrl.sv
// Branch/jump resolution: decodes requests, resolves targets via a LUT or the link stack,
// and latches a sticky error on stack overflow/underflow.
module jump_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned D  = DefD,
  parameter int unsigned LA = DefLA,
  parameter int unsigned SD = DefSD
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_br_valid,
  input  logic [1:0]    i_br_op,
  input  logic          i_cond,
  input  logic [LA-1:0] i_lut_idx,
  input  logic [D-1:0]  i_prog_ctr,
  input  logic          i_lut_we,
  input  logic [LA-1:0] i_lut_waddr,
  input  logic [D-1:0]  i_lut_wdata,
  output logic          o_jump_en,
  output logic [D-1:0]  o_target,
  output logic          o_stack_full,
  output logic          o_stack_empty,
  output logic          o_err
);

  localparam int unsigned LutN = 2 ** LA;

  jc_state_t    r_state;
  jc_state_t    w_state_next;
  logic [D-1:0] r_lut [LutN];
  br_op_t       w_op;
  logic         w_req;
  logic         w_push;
  logic         w_pop;
  logic [D-1:0] w_top;
  logic [D-1:0] w_ret_addr;

  assign w_op       = br_op_t'(i_br_op);
  assign w_req      = i_br_valid && (w_op != OpNone);
  assign w_ret_addr = i_prog_ctr + D'(1);
  assign o_err      = (r_state == StErr);

  link_stack #(
    .D  (D),
    .SD (SD)
  ) u_link_stack (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_ret_addr),
    .o_top   (w_top),
    .o_full  (o_stack_full),
    .o_empty (o_stack_empty)
  );

  // Reads see the pre-edge table, so a same-cycle write is visible only next cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < LutN; i++) r_lut[i] <= '0;
    end else if (i_lut_we) begin
      r_lut[i_lut_waddr] <= i_lut_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= StRun;
    else         r_state <= w_state_next;
  end

  always_comb begin
    o_jump_en    = 1'b0;
    o_target     = '0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_state_next = r_state;
    if (w_req && (r_state == StRun)) begin
      unique case (w_op)
        OpBranch: begin
          o_jump_en = i_cond;
          o_target  = r_lut[i_lut_idx];
        end
        OpCall: begin
          o_target = r_lut[i_lut_idx];
          if (!o_stack_full) begin
            o_jump_en = 1'b1;
            w_push    = 1'b1;
          end else begin
            w_state_next = StErr;
          end
        end
        OpRet: begin
          if (!o_stack_empty) begin
            o_jump_en = 1'b1;
            o_target  = w_top;
            w_pop     = 1'b1;
          end else begin
            w_state_next = StErr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: directed scenarios plus random traffic against a queue model.
module tb_jump_ctrl;

  localparam int D  = 6;
  localparam int LA = 4;
  localparam int SD = 4;

  logic          clk;
  logic          reset;
  logic          br_valid;
  logic [1:0]    br_op;
  logic          cond;
  logic [LA-1:0] lut_idx;
  logic [D-1:0]  prog_ctr;
  logic          lut_we;
  logic [LA-1:0] lut_waddr;
  logic [D-1:0]  lut_wdata;
  logic          jump_en;
  logic [D-1:0]  target;
  logic          stack_full;
  logic          stack_empty;
  logic          err;

  jump_ctrl #(
    .D  (D),
    .LA (LA),
    .SD (SD)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_br_valid    (br_valid),
    .i_br_op       (br_op),
    .i_cond        (cond),
    .i_lut_idx     (lut_idx),
    .i_prog_ctr    (prog_ctr),
    .i_lut_we      (lut_we),
    .i_lut_waddr   (lut_waddr),
    .i_lut_wdata   (lut_wdata),
    .o_jump_en     (jump_en),
    .o_target      (target),
    .o_stack_full  (stack_full),
    .o_stack_empty (stack_empty),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_lut [2**LA];
  int m_stk [$];
  bit m_err;

  int obs_je;
  int obs_tg;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2**LA; i++) m_lut[i] = 0;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  // Called at posedge+1: drive, sample at +3, then advance one edge and update the model.
  task automatic step(input bit v, input int op, input bit c, input int idx, input int pc,
                      input bit we, input int wa, input int wd);
    int  exp_je;
    int  exp_tg;
    bit  chk_tg;
    bit  do_push;
    bit  do_pop;
    bit  set_err;
    bit  eff;
    br_valid  = v;
    br_op     = 2'(op);
    cond      = c;
    lut_idx   = LA'(idx);
    prog_ctr  = D'(pc);
    lut_we    = we;
    lut_waddr = LA'(wa);
    lut_wdata = D'(wd);
    #2;
    eff     = v && (op != 0);
    exp_je  = 0;
    exp_tg  = 0;
    chk_tg  = 1'b1;
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_err = 1'b0;
    if (!eff) begin
      exp_tg = 0;
    end else if (m_err) begin
      chk_tg = 1'b0;
    end else if (op == 1) begin
      exp_je = c;
      exp_tg = m_lut[idx];
    end else if (op == 2) begin
      if (m_stk.size() < SD) begin
        exp_je  = 1;
        exp_tg  = m_lut[idx];
        do_push = 1'b1;
      end else begin
        chk_tg  = 1'b0;
        set_err = 1'b1;
      end
    end else begin
      if (m_stk.size() > 0) begin
        exp_je = 1;
        exp_tg = m_stk[m_stk.size()-1];
        do_pop = 1'b1;
      end else begin
        chk_tg  = 1'b0;
        set_err = 1'b1;
      end
    end
    obs_je = int'(jump_en);
    obs_tg = int'(target);
    check_eq("jump_en", obs_je, exp_je);
    if (chk_tg) check_eq("target", obs_tg, exp_tg);
    check_eq("stack_full", int'(stack_full), int'(m_stk.size() == SD));
    check_eq("stack_empty", int'(stack_empty), int'(m_stk.size() == 0));
    check_eq("err", int'(err), int'(m_err));
    @(posedge clk);
    if (do_push) m_stk.push_back((pc + 1) % (2**D));
    if (do_pop) void'(m_stk.pop_back());
    if (set_err) m_err = 1'b1;
    if (we) m_lut[wa] = wd % (2**D);
    #1;
  endtask

  task automatic idle_inputs();
    br_valid  = 1'b0;
    br_op     = 2'd0;
    cond      = 1'b0;
    lut_idx   = '0;
    prog_ctr  = '0;
    lut_we    = 1'b0;
    lut_waddr = '0;
    lut_wdata = '0;
  endtask

  // Asynchronous pulse between edges; effects must show before any clock edge.
  task automatic reset_pulse();
    idle_inputs();
    #1;
    reset = 1'b1;
    #1;
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_empty", int'(stack_empty), 1);
    check_eq("rst_full", int'(stack_full), 0);
    check_eq("rst_jump_en", int'(jump_en), 0);
    check_eq("rst_target", int'(target), 0);
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check_eq("init_jump_en", int'(jump_en), 0);
    check_eq("init_target", int'(target), 0);
    check_eq("init_full", int'(stack_full), 0);
    check_eq("init_empty", int'(stack_empty), 1);
    check_eq("init_err", int'(err), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // LUT cleared by reset
    step(1, 1, 1, 3, 0, 0, 0, 0);
    check_eq("plan_clr_je", obs_je, 1);
    check_eq("plan_clr_tg", obs_tg, 0);

    // LUT write/read and same-cycle write
    step(0, 0, 0, 0, 0, 1, 3, 5);
    step(1, 1, 1, 3, 0, 0, 0, 0);
    check_eq("plan_lut_tg", obs_tg, 5);
    step(1, 1, 0, 3, 0, 0, 0, 0);
    check_eq("plan_nc_je", obs_je, 0);
    step(1, 1, 1, 3, 0, 1, 3, 9);
    check_eq("plan_wr_old", obs_tg, 5);
    step(1, 1, 1, 3, 0, 0, 0, 0);
    check_eq("plan_wr_new", obs_tg, 9);

    // Call/return, nested
    step(0, 0, 0, 0, 0, 1, 2, 40);
    step(1, 2, 0, 2, 10, 0, 0, 0);
    check_eq("plan_call_tg", obs_tg, 40);
    check_eq("plan_call_nonempty", int'(stack_empty), 0);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    check_eq("plan_ret_tg", obs_tg, 11);
    check_eq("plan_ret_empty", int'(stack_empty), 1);
    step(1, 2, 0, 2, 10, 0, 0, 0);
    step(1, 2, 0, 2, 20, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    check_eq("plan_nest1", obs_tg, 21);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    check_eq("plan_nest2", obs_tg, 11);

    // Return-address wrap
    step(1, 2, 0, 2, 63, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    check_eq("plan_wrap", obs_tg, 0);

    // Overflow
    for (int i = 0; i < SD; i++) step(1, 2, 0, 2, i, 0, 0, 0);
    check_eq("plan_full", int'(stack_full), 1);
    step(1, 2, 0, 2, 30, 0, 0, 0);
    check_eq("plan_ovf_je", obs_je, 0);
    check_eq("plan_ovf_err", int'(err), 1);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    check_eq("plan_err_ret_je", obs_je, 0);
    check_eq("plan_err_full", int'(stack_full), 1);
    reset_pulse();

    // Underflow and recovery
    step(1, 3, 0, 0, 0, 0, 0, 0);
    check_eq("plan_unf_je", obs_je, 0);
    check_eq("plan_unf_err", int'(err), 1);
    reset_pulse();
    step(0, 0, 0, 0, 0, 1, 3, 7);
    step(1, 1, 1, 3, 0, 0, 0, 0);
    check_eq("plan_recover_je", obs_je, 1);
    check_eq("plan_recover_tg", obs_tg, 7);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int pc;
      if ((n % 60) == 59) reset_pulse();
      pc = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 63));
      step($urandom_range(0, 7) != 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), pc, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 63)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Branch/jump resolution stage directly upstream of the program counter. Each cycle it decodes the current control-flow request from the decoder, resolves the destination through a programmable jump-target lookup table or an internal link (return-address) stack, and drives the counter's `jump_en`/`target` pair. A sticky error state suppresses further jumps after a stack overflow or underflow, until reset.

## Interface
Parameters:
- `D`, 6: program-counter width; must match the counter's `D`.
- `LA`, 4: lookup-table address width; the table has 2^LA entries.
- `SD`, 4: link-stack depth (entries); power of two, ≥2.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `br_valid`  in  1  a control-flow request is present this cycle.
- `br_op`  in  2  request type: 00 NONE, 01 BRANCH (conditional), 10 CALL, 11 RET.
- `cond`  in  1  branch condition flag from the ALU; used only by BRANCH.
- `lut_idx`  in  LA  table index for BRANCH/CALL destinations.
- `prog_ctr`  in  D  current program counter value.
- `lut_we`  in  1  table write enable.
- `lut_waddr`  in  LA  table write address.
- `lut_wdata`  in  D  table write data.
- `jump_en`  out  1  to the counter: load `target` on the next edge.
- `target`  out  D  jump destination.
- `stack_full`  out  1  link stack holds SD entries.
- `stack_empty`  out  1  link stack holds 0 entries.
- `err`  out  1  sticky overflow/underflow flag.

## Operation
- FSM states: RUN, ERR. Reset → RUN.
- RUN, effective request: `br_valid`=1 and `br_op`≠NONE:
  - BRANCH: `jump_en`=`cond`; `target`=LUT[`lut_idx`]. The stack is unchanged.
  - CALL, not full: `jump_en`=1; `target`=LUT[`lut_idx`]; push (`prog_ctr`+1) mod 2^D.
  - CALL, full: `jump_en`=0; no push; next state ERR.
  - RET, not empty: `jump_en`=1; `target`=top of stack; pop.
  - RET, empty: `jump_en`=0; no pop; next state ERR.
- No effective request (`br_valid`=0 or `br_op`=NONE): `jump_en`=0 and `target`=0.
- ERR: `jump_en`=0 for all requests; push and pop are suppressed; `err`=1. ERR is left only by reset.
- LUT writes are accepted in both states.
- A write and a read of the same index in the same cycle: the read returns the old value; the new value is visible from the next cycle.
- Stack pointer range is 0..SD. `stack_full` = (ptr==SD); `stack_empty` = (ptr==0).
- The return-address increment wraps, so 2^D−1 yields 0.

## Timing
- `jump_en` and `target` are combinational from the current inputs and state. The counter registers them on the next rising edge, giving 1-cycle redirect latency.
- Stack pointer, stack contents, LUT and FSM state update on the rising edge.
- Flags reflect post-edge state. `err` is registered and rises in the cycle after the faulting request.
- Reset values: all outputs 0 except `stack_empty`=1; stack pointer 0; all LUT entries 0; state RUN.
- Reset asserted mid-operation clears all of the above immediately, independent of `clk`.

## Structure
- Shared package `cpu_pkg`:
  - `br_op_t` enum (NONE, BRANCH, CALL, RET).
  - `jc_state_t` enum (RUN, ERR).
  - Default constants for D, LA and SD.
- One sub-module, `link_stack`: parameterized by D and SD; ports `push`, `pop`, `din`, `top`, `full`, `empty`; asynchronous reset.
- The LUT is a register array inside `jump_ctrl`.

## Test plan
- **Reset:** hold `reset`=1 → all outputs 0, `stack_empty`=1. Deassert, then BRANCH `cond`=1 with `lut_idx`=3 → `target`=0 (LUT cleared), `jump_en`=1.
- **LUT write/read:** write LUT[3]=5, then BRANCH `cond`=1, `lut_idx`=3 → `jump_en`=1, `target`=5. Repeat with `cond`=0 → `jump_en`=0. Same-cycle write LUT[3]=9 with a read of index 3 → `target`=5; next cycle → 9.
- **Call/return:** LUT[2]=40; CALL at `prog_ctr`=10 with `lut_idx`=2 → `target`=40 and `stack_empty` falls. RET → `target`=11, `stack_empty`=1. Nested CALLs at 10 and 20 → RETs give 21 then 11.
- **Wrap:** CALL at `prog_ctr`=63 (D=6) → subsequent RET gives `target`=0.
- **Overflow:** SD=4 CALLs → `stack_full`=1. A 5th CALL → `jump_en`=0 and `err`=1 on the next cycle. A RET afterwards → `jump_en`=0 and the stack pointer is unchanged.
- **Underflow and reset recovery:** RET on empty → `jump_en`=0, then `err`=1. Async `reset` pulse between edges → `err`=0 immediately. A following BRANCH operates normally.
